dense_layer1_mac: RTL and testbench

- Fully-connected layer-1 compute stage. Sits directly downstream of the layer-1 weight loader.
- Consumes the loader's flattened weight bus and an input activation vector. Computes OUT_SIZE dot products of length IN_SIZE with OUT_SIZE parallel MACs, one input index per cycle.
- Requantizes each result to W-bit signed and presents them on a flat output bus with a level done flag.

---
 rtl/dense_layer1_mac.sv | 176 +++++++++++++++++
 tb/tb_dense_layer1_mac.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer1_mac.sv
// Fully-connected layer-1 MAC stage: OUT_SIZE parallel lanes, one input index per cycle,
// then requantize (shift + saturate). Optional ReLU on outputs via `define DENSE_RELU_EN.
module dense_layer1_mac #(
    parameter int unsigned IN_SIZE  = 1152,
    parameter int unsigned OUT_SIZE = 8,
    parameter int unsigned W        = 8,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned SHIFT    = 7,
    parameter int unsigned IDX_W    = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         weights_valid,
    input  logic [IN_SIZE*OUT_SIZE*W-1:0] weights_in,
    input  logic [IN_SIZE*W-1:0]          data_in,
    output logic [OUT_SIZE*W-1:0]         data_out,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned P_W = 2 * W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_SIZE - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (W - 1)) - 1);
    // ~(2^(W-1)-1) is -2^(W-1) in two's complement
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_REQUANT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    r_busy;
    logic                    r_done;

    logic [IDX_W-1:0]        r_idx;
    logic                    r_prod_vld;
    logic signed [P_W-1:0]   r_prod [OUT_SIZE];
    logic signed [ACC_W-1:0] r_acc  [OUT_SIZE];
    logic [OUT_SIZE*W-1:0]   r_data_out;

    logic signed [W-1:0]     w_x;
    logic signed [W-1:0]     w_wgt  [OUT_SIZE];
    logic signed [P_W-1:0]   w_prod [OUT_SIZE];
    logic signed [ACC_W-1:0] w_shr  [OUT_SIZE];
    logic signed [ACC_W-1:0] w_sat  [OUT_SIZE];
    logic [W-1:0]            w_q    [OUT_SIZE];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and registered-flag decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start && weights_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN:   w_state_nxt = S_REQUANT;
            S_REQUANT: w_state_nxt = S_DONE;
            default:   w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == S_MAC) || (w_state_nxt == S_DRAIN) ||
                     (w_state_nxt == S_REQUANT);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    // Per-lane operand select and full-width signed product
    always_comb begin
        w_x = data_in[int'(r_idx)*W +: W];
        for (int o = 0; o < int'(OUT_SIZE); o++) begin
            w_wgt[o]  = weights_in[(o*IN_SIZE + int'(r_idx))*W +: W];
            w_prod[o] = P_W'(w_x) * P_W'(w_wgt[o]);
        end
    end

    // Requantization: arithmetic shift, saturate, optional ReLU
    always_comb begin
        for (int o = 0; o < int'(OUT_SIZE); o++) begin
            w_shr[o] = r_acc[o] >>> SHIFT;
            if (w_shr[o] > SAT_MAX) begin
                w_sat[o] = SAT_MAX;
            end else if (w_shr[o] < SAT_MIN) begin
                w_sat[o] = SAT_MIN;
            end else begin
                w_sat[o] = w_shr[o];
            end
            w_q[o] = w_sat[o][W-1:0];
`ifdef DENSE_RELU_EN
            if (w_sat[o][ACC_W-1]) begin
                w_q[o] = '0;
            end
`endif
        end
    end

    // Datapath: index counter, product pipeline, accumulators, output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_prod_vld <= 1'b0;
            r_data_out <= '0;
            for (int o = 0; o < int'(OUT_SIZE); o++) begin
                r_prod[o] <= '0;
                r_acc[o]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_idx      <= '0;
                        r_prod_vld <= 1'b0;
                        for (int o = 0; o < int'(OUT_SIZE); o++) begin
                            r_acc[o] <= '0;
                        end
                    end
                end
                S_MAC: begin
                    r_idx      <= r_idx + IDX_W'(1);
                    r_prod_vld <= 1'b1;
                    for (int o = 0; o < int'(OUT_SIZE); o++) begin
                        r_prod[o] <= w_prod[o];
                        if (r_prod_vld) begin
                            r_acc[o] <= r_acc[o] + ACC_W'(r_prod[o]);
                        end
                    end
                end
                S_DRAIN: begin
                    for (int o = 0; o < int'(OUT_SIZE); o++) begin
                        if (r_prod_vld) begin
                            r_acc[o] <= r_acc[o] + ACC_W'(r_prod[o]);
                        end
                    end
                end
                S_REQUANT: begin
                    for (int o = 0; o < int'(OUT_SIZE); o++) begin
                        r_data_out[o*W +: W] <= w_q[o];
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_dense_layer1_mac.sv
// Bench for dense_layer1_mac: two instances (SHIFT=0 and SHIFT=2) share stimulus; table vectors,
// corner sequences and random passes against a sum-of-products reference model.
module tb_dense_layer1_mac;

    localparam int unsigned IN_SIZE  = 4;
    localparam int unsigned OUT_SIZE = 2;
    localparam int unsigned W        = 8;
    localparam int unsigned ACC_W    = 32;
    localparam int unsigned IDX_W    = 3;

    typedef struct packed {
        logic [3:0][7:0] x;
        logic [3:0][7:0] w0;
        logic [3:0][7:0] w1;
        logic [1:0][7:0] e0;   // expected outputs, SHIFT=0 instance
        logic [1:0][7:0] e2;   // expected outputs, SHIFT=2 instance
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        weights_valid;
    logic [63:0] weights_in;
    logic [31:0] data_in;
    logic [15:0] out_s0, out_s2;
    logic        busy_s0, done_s0, busy_s2, done_s2;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0][7:0] prev_s0, prev_s2;
    vec_t tab [6];

    always #5 clk = ~clk;

    dense_layer1_mac #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W),
                       .SHIFT(0), .IDX_W(IDX_W)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start), .weights_valid(weights_valid),
        .weights_in(weights_in), .data_in(data_in), .data_out(out_s0),
        .busy(busy_s0), .done(done_s0));

    dense_layer1_mac #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W),
                       .SHIFT(2), .IDX_W(IDX_W)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start), .weights_valid(weights_valid),
        .weights_in(weights_in), .data_in(data_in), .data_out(out_s2),
        .busy(busy_s2), .done(done_s2));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int lane(input logic [15:0] b, input int o);
        logic [7:0] t;
        t = b[o*8 +: 8];
        return sx(t);
    endfunction

    function automatic int rl(input int v);
`ifdef DENSE_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [3:0][7:0] mk4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    function automatic logic [1:0][7:0] mk2(input int a, input int b);
        logic [1:0][7:0] r;
        r[0] = 8'(rl(a)); r[1] = 8'(rl(b));
        return r;
    endfunction

    // Reference: exact dot product, floor-shift, clamp to int8, optional ReLU
    function automatic int model(input vec_t v, input int o, input int sh);
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
            s += longint'(sx(v.x[i])) * longint'(sx((o == 0) ? v.w0[i] : v.w1[i]));
        end
        s = s >>> sh;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return rl(int'(s));
    endfunction

    task automatic check_state(input string tag, input bit exp_busy, input bit exp_done,
                               input logic [1:0][7:0] e0, input logic [1:0][7:0] e2);
        check({tag, " busy_s0"}, int'(busy_s0), int'(exp_busy));
        check({tag, " done_s0"}, int'(done_s0), int'(exp_done));
        check({tag, " busy_s2"}, int'(busy_s2), int'(exp_busy));
        check({tag, " done_s2"}, int'(done_s2), int'(exp_done));
        for (int o = 0; o < 2; o++) begin
            check($sformatf("%s y%0d_s0", tag, o), lane(out_s0, o), sx(e0[o]));
            check($sformatf("%s y%0d_s2", tag, o), lane(out_s2, o), sx(e2[o]));
        end
    endtask

    task automatic apply(input vec_t v);
        data_in    = v.x;
        weights_in = {v.w1, v.w0};
    endtask

    // One full pass: fixed latency, busy window, output hold, then DONE
    task automatic do_pass(input vec_t v, input bit mid_start, input bit wv_drop,
                           input string tag);
        apply(v);
        start         = 1'b1;
        weights_valid = 1'b1;
        tick();
        start = 1'b0;
        if (wv_drop) weights_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_state($sformatf("%s c%0d", tag, k), 1'b1, 1'b0, prev_s0, prev_s2);
            start = mid_start && (k == 1);
            tick();
        end
        start         = 1'b0;
        weights_valid = 1'b1;
        check_state({tag, " done"}, 1'b0, 1'b1, v.e0, v.e2);
        tick();
        check_state({tag, " hold"}, 1'b0, 1'b1, v.e0, v.e2);
        prev_s0 = v.e0;
        prev_s2 = v.e2;
    endtask

    initial begin
        vec_t v;

        tab[0].x = mk4(1, 2, 3, 4);        tab[0].w0 = mk4(1, 1, 1, 1);
        tab[0].w1 = mk4(-1, 0, 0, 0);      tab[0].e0 = mk2(10, -1);    tab[0].e2 = mk2(2, -1);
        tab[1].x = mk4(127, 127, 127, 127); tab[1].w0 = mk4(127, 127, 127, 127);
        tab[1].w1 = mk4(-128, -128, -128, -128);
        tab[1].e0 = mk2(127, -128);        tab[1].e2 = mk2(127, -128);
        tab[2].x = mk4(1, 0, 0, 0);        tab[2].w0 = mk4(-5, 0, 0, 0);
        tab[2].w1 = mk4(6, 0, 0, 0);       tab[2].e0 = mk2(-5, 6);     tab[2].e2 = mk2(-2, 1);
        tab[3].x = mk4(0, 0, 0, 0);        tab[3].w0 = mk4(9, -9, 9, -9);
        tab[3].w1 = mk4(-7, 7, -7, 7);     tab[3].e0 = mk2(0, 0);      tab[3].e2 = mk2(0, 0);
        tab[4].x = mk4(-128, -128, -128, -128); tab[4].w0 = mk4(-128, -128, -128, -128);
        tab[4].w1 = mk4(1, -1, 1, -1);     tab[4].e0 = mk2(127, 0);    tab[4].e2 = mk2(127, 0);
        tab[5].x = mk4(3, -2, 5, -7);      tab[5].w0 = mk4(2, 4, -1, 1);
        tab[5].w1 = mk4(-3, -3, -3, -3);   tab[5].e0 = mk2(-14, 3);    tab[5].e2 = mk2(-4, 0);

        rst = 1'b1; start = 1'b0; weights_valid = 1'b0;
        data_in = '0; weights_in = '0;
        prev_s0 = '0; prev_s2 = '0;
        tick();
        tick();
        check_state("reset", 1'b0, 1'b0, '0, '0);
        rst = 1'b0;

        // start without weights_valid must be ignored
        apply(tab[0]);
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_state($sformatf("gate%0d", k), 1'b0, 1'b0, '0, '0);
        end
        start = 1'b0;

        // table passes; each after the first restarts from DONE
        for (int t = 0; t < 6; t++) begin
            do_pass(tab[t], 1'b0, 1'b0, $sformatf("tab%0d", t));
        end

        do_pass(tab[0], 1'b1, 1'b0, "midstart");

        // reset while idx=2
        apply(tab[1]);
        start = 1'b1; weights_valid = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_state("rstmid", 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        prev_s0 = '0; prev_s2 = '0;
        tick();
        check_state("rstidle", 1'b0, 1'b0, '0, '0);
        do_pass(tab[0], 1'b0, 1'b0, "postrst");

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                v.x[i]  = 8'($urandom_range(255));
                v.w0[i] = 8'($urandom_range(255));
                v.w1[i] = 8'($urandom_range(255));
                if (r % 4 == 0) begin
                    v.x[i]  = $urandom_range(1) ? 8'h7f : 8'h80;
                    v.w0[i] = $urandom_range(1) ? 8'h7f : 8'h80;
                end
            end
            for (int o = 0; o < 2; o++) begin
                v.e0[o] = 8'(model(v, o, 0));
                v.e2[o] = 8'(model(v, o, 2));
            end
            do_pass(v, r[0], r[1], $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
